// File: rtl/pipe_skid_stage_pkg.sv
// Shared types for the skid-buffered pipeline stage: FSM state, occupancy type and helpers.
// The state encoding is {skid_valid, main_valid}, so the two valid bits are read straight off the state.
package pipe_pkg;

  localparam int OCC_MAX = 2;

  typedef logic [1:0] occ_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b11
  } stage_st_e;

  function automatic occ_t occ_of(stage_st_e st);
    occ_t occ;
    case (st)
      ST_EMPTY: occ = 2'd0;
      ST_ONE:   occ = 2'd1;
      ST_FULL:  occ = occ_t'(OCC_MAX);
      default:  occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_skid_stage_if.sv
// Upstream and downstream valid/ready/data bundle of one pipeline stage.
// The stage itself takes the slave modport; the environment drives the master side.
interface pipe_skid_stage_if #(
  parameter int DATA_W = 64
) ();
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipe_sat_cnt.sv
// Saturating event counter: increments on inc, sticks at all-ones, clears on async rst.
module pipe_sat_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);
  logic [CNT_W-1:0] cnt_r;

  // Count register, frozen once it reaches all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (inc && (cnt_r != {CNT_W{1'b1}})) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt = cnt_r;
endmodule

// File: rtl/pipe_skid_stage_chk.sv
// Property checker for pipe_skid_stage: legal state encoding and stable output while stalled.
module pipe_skid_stage_chk #(
  parameter int DATA_W = 64
) (
  input logic              clk,
  input logic              rst,
  input logic              hold,
  input logic              flush,
  input logic              main_valid,
  input logic              skid_valid,
  input logic              out_ready,
  input logic [DATA_W-1:0] out_data
);
  a_skid_implies_main: assert property (@(posedge clk) disable iff (rst)
    skid_valid |-> main_valid);

  // A presented entry must not change until it is taken or squashed.
  a_out_stable: assert property (@(posedge clk) disable iff (rst)
    (main_valid && (hold || (!out_ready && !flush))) |=> $stable(out_data));
endmodule

// File: rtl/pipe_skid_stage.sv
// Pipeline stage register with a 2-entry skid buffer, global hold/flush and registered in_ready.
// Optional statistics counters are enabled with the PIPE_STAGE_STAT_EN macro.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int                DATA_W = 64,
  parameter logic [DATA_W-1:0] BUBBLE = {DATA_W{1'b0}},
  parameter int                CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 hold,
  input  logic                 flush,
  pipe_skid_stage_if.slave     bus,
  output occ_t                 occupancy,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     flush_cnt
);
  stage_st_e         state_r, state_nxt_s;
  logic [DATA_W-1:0] main_data_r, main_data_nxt_s;
  logic [DATA_W-1:0] skid_data_r, skid_data_nxt_s;
  logic              main_valid_s, skid_valid_s;
  logic              in_ready_s, in_fire_s, out_fire_s;

  assign main_valid_s = state_r[0];
  assign skid_valid_s = state_r[1];
  assign in_ready_s   = ~skid_valid_s & ~hold;
  assign in_fire_s    = bus.in_valid & in_ready_s & ~flush;
  assign out_fire_s   = main_valid_s & bus.out_ready & ~hold;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_EMPTY;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: hold freezes, flush empties, otherwise follow the handshakes.
  always_comb begin
    state_nxt_s = state_r;
    if (hold) begin
      state_nxt_s = state_r;
    end else if (flush) begin
      state_nxt_s = ST_EMPTY;
    end else begin
      case (state_r)
        ST_EMPTY: state_nxt_s = in_fire_s ? ST_ONE : ST_EMPTY;
        ST_ONE: begin
          if (in_fire_s && !out_fire_s) begin
            state_nxt_s = ST_FULL;
          end else if (!in_fire_s && out_fire_s) begin
            state_nxt_s = ST_EMPTY;
          end else begin
            state_nxt_s = ST_ONE;
          end
        end
        ST_FULL:  state_nxt_s = out_fire_s ? ST_ONE : ST_FULL;
        default:  state_nxt_s = ST_EMPTY;
      endcase
    end
  end

  // Payload steering for the main and skid entries.
  always_comb begin
    main_data_nxt_s = main_data_r;
    skid_data_nxt_s = skid_data_r;
    if (hold) begin
      main_data_nxt_s = main_data_r;
      skid_data_nxt_s = skid_data_r;
    end else if (flush) begin
      main_data_nxt_s = BUBBLE;
      skid_data_nxt_s = BUBBLE;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (in_fire_s) begin
            main_data_nxt_s = bus.in_data;
          end else begin
            main_data_nxt_s = main_data_r;
          end
        end
        ST_ONE: begin
          // Downstream stalled while a new beat arrives: park it in the skid entry.
          if (in_fire_s && out_fire_s) begin
            main_data_nxt_s = bus.in_data;
          end else if (in_fire_s) begin
            skid_data_nxt_s = bus.in_data;
          end else begin
            main_data_nxt_s = main_data_r;
          end
        end
        ST_FULL: begin
          if (out_fire_s) begin
            main_data_nxt_s = skid_data_r;
            skid_data_nxt_s = BUBBLE;
          end else begin
            skid_data_nxt_s = skid_data_r;
          end
        end
        default: begin
          main_data_nxt_s = BUBBLE;
          skid_data_nxt_s = BUBBLE;
        end
      endcase
    end
  end

  // Payload registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_data_r <= BUBBLE;
      skid_data_r <= BUBBLE;
    end else begin
      main_data_r <= main_data_nxt_s;
      skid_data_r <= skid_data_nxt_s;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = main_valid_s;
  assign bus.out_data  = main_data_r;
  assign occupancy     = occ_of(state_r);

`ifdef PIPE_STAGE_STAT_EN
  pipe_sat_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (main_valid_s & (~bus.out_ready | hold)),
    .cnt (stall_cnt)
  );

  pipe_sat_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (flush & ~hold),
    .cnt (flush_cnt)
  );
`else
  assign stall_cnt = {CNT_W{1'b0}};
  assign flush_cnt = {CNT_W{1'b0}};
`endif

  pipe_skid_stage_chk #(.DATA_W(DATA_W)) u_chk (
    .clk        (clk),
    .rst        (rst),
    .hold       (hold),
    .flush      (flush),
    .main_valid (main_valid_s),
    .skid_valid (skid_valid_s),
    .out_ready  (bus.out_ready),
    .out_data   (main_data_r)
  );
endmodule

// File: doc/pipe_skid_stage.md
Name: pipe_skid_stage

Overview:
Parametrised pipeline stage register, successor to the fixed IF/ID latch. Carries a DATA_W-bit payload with a valid/ready handshake. Includes a 2-entry skid buffer, so upstream ready is registered and never depends combinationally on downstream ready. Instantiated between any two CPU pipeline stages (IF/ID, ID/EX, …), with global freeze (hold) and flush (bubble insertion) controls.

Parameters:
DATA_W, 64, payload width in bits (e.g. pc+inst)
BUBBLE, {DATA_W{1'b0}}, payload value loaded on reset/flush
CNT_W, 16, width of statistics counters (used only with PIPE_STAGE_STAT_EN)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous reset, active-high
hold  in  1  global freeze (CPU/memory stall); highest priority after rst
flush  in  1  squash all held entries and same-cycle input
in_valid  in  1  upstream payload valid
in_data  in  DATA_W  upstream payload
in_ready  out  1  stage can accept; registered
out_valid  out  1  main entry valid
out_data  out  DATA_W  main entry payload
out_ready  in  1  downstream accepts
occupancy  out  2  entries held: 0, 1 or 2
stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0 (macro)
flush_cnt  out  CNT_W  flush events accepted (macro)

Behaviour:
- Reset (async, active-high): main_valid=0, skid_valid=0, out_data=BUBBLE, skid data=BUBBLE, in_ready=1, occupancy=0, counters=0.
- Handshakes: in_fire = in_valid & in_ready & ~hold & ~flush; out_fire = out_valid & out_ready & ~hold.
- in_ready = ~skid_valid & ~hold. The skid_valid term is a register. hold gates it combinationally.
- Priority per cycle: rst > hold > flush > normal.
- hold=1: every register keeps its value. This includes the counters, except that stall_cnt still counts when out_valid=1. Inputs are ignored.
- flush=1 (hold=0): next cycle main_valid=0, skid_valid=0, both data=BUBBLE, occupancy=0. Same-cycle in_data is dropped. Same-cycle out_fire is still a completed transfer; downstream flush handling is its own concern.
- States, encoded by {skid_valid, main_valid}:
  - EMPTY (00):
    - in_fire -> ONE, main<=in_data.
  - ONE (01):
    - in_fire & out_fire -> ONE, main<=in_data.
    - out_fire only -> EMPTY, main data keeps its last value.
    - in_fire only -> FULL, skid<=in_data.
  - FULL (11):
    - out_fire -> ONE, main<=skid, skid data<=BUBBLE.
    - no in_fire is possible (in_ready=0).
  - State 10 is illegal and unreachable. Assertion: skid_valid implies main_valid.
- Latency: 1 cycle in->out when empty. Throughput: 1/cycle sustained. Ordering: strict FIFO.
- out_data is stable while out_valid=1 and not fired.
- A registered in_ready means the skid absorbs the one transfer accepted in the cycle when downstream stalls.

Optional Feature:
Macro PIPE_STAGE_STAT_EN.
- Defined:
  - stall_cnt increments each cycle with out_valid=1 and (out_ready=0 or hold=1).
  - flush_cnt increments each cycle with flush=1 and hold=0.
  - Both saturate at all-ones and clear on rst.
- Undefined: both ports are driven constant 0 and no counter flops are inferred. Port list is identical either way.

Decomposition:
- Package pipe_pkg:
  - state enum stage_st_e {ST_EMPTY, ST_ONE, ST_FULL}
  - typedef for occupancy (logic [1:0])
  - localparam OCC_MAX=2
- One natural sub-module: pipe_sat_cnt, a saturating CNT_W counter with inc and async active-high rst. It is instantiated twice under PIPE_STAGE_STAT_EN.

Test Plan:
1. Reset mid-stream: fill FULL with 0xA, 0xB, assert rst for 1 cycle -> same edge: out_valid=0, occupancy=0, in_ready=1, out_data=BUBBLE.
2. Streaming: in_valid=1 with 0x1..0x8 on consecutive cycles, out_ready=1 -> out_data 0x1..0x8 one per cycle, 1-cycle latency, occupancy stays 1.
3. Backpressure: send 0x10, 0x11, 0x12 with out_ready=0 -> occupancy 2 after 0x11, in_ready=0 next cycle, 0x12 held upstream. Release out_ready -> output 0x10, 0x11, 0x12 in order, no loss or duplication.
4. Flush in FULL with simultaneous in_valid=1 (0x20) -> next cycle occupancy=0, out_valid=0, out_data=BUBBLE, 0x20 not delivered. With the macro, flush_cnt=1.
5. Hold over flush: hold=1 and flush=1 together in ONE holding 0x30 -> state, out_data=0x30, flush_cnt unchanged. Deassert hold with flush=0 -> 0x30 delivered.
6. Counter saturation (macro, CNT_W=4): out_valid=1, out_ready=0 for 20 cycles -> stall_cnt=15 and holds at 15. Without the macro, stall_cnt=flush_cnt=0 throughout.
